// File: rtl/stack_unit.sv
// LIFO stack with registered pop port, combinational top-of-stack and sticky error flags.
// Pop latency 1 cycle; rejected pushes/pops set overflow/underflow instead of stalling.
module stack_unit #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       StackPush,
  input  logic                       StackPop,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_sp;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_pop_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic [AW:0]      w_sp_m1;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_both;
  logic             w_wr_en;
  logic             w_pop_ok;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign w_full      = (r_sp == (AW+1)'(DEPTH));
  assign w_empty     = (r_sp == '0);
  assign w_sp_m1     = r_sp - 1'b1;
  assign w_top_idx   = w_sp_m1[AW-1:0];
  assign w_push_only = StackPush && !StackPop;
  assign w_pop_only  = StackPop && !StackPush;
  assign w_both      = StackPush && StackPop;

  // A push+pop on a non-empty stack overwrites the top in place; on an empty stack it degrades to a plain push.
  assign w_wr_en   = (w_push_only && !w_full) || w_both;
  assign w_wr_idx  = (w_both && !w_empty) ? w_top_idx : r_sp[AW-1:0];
  assign w_pop_ok  = StackPop && !w_empty;
  assign w_ovf_set = w_push_only && w_full;
  assign w_unf_set = StackPop && w_empty;

  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp        <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_pop_data <= r_mem[w_top_idx];
      end
      if ((w_push_only && !w_full) || (w_both && w_empty)) begin
        r_sp <= r_sp + 1'b1;
      end else if (w_pop_only && !w_empty) begin
        r_sp <= w_sp_m1;
      end
      // Set wins over clear so an error on the clearing edge is not lost.
      r_overflow  <= (r_overflow  && !clear_err) || w_ovf_set;
      r_underflow <= (r_underflow && !clear_err) || w_unf_set;
    end
  end

  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign top_data  = w_empty ? '0 : r_mem[w_top_idx];
  assign sp        = r_sp;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: a scoreboard queue holds expected pop words, a negedge monitor checks them.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        StackPush;
  logic        StackPop;
  logic [31:0] push_data;
  logic        clear_err;
  logic [31:0] pop_data;
  logic        pop_valid;
  logic [31:0] top_data;
  logic [4:0]  sp;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  stack_unit #(.DEPTH(16), .WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .StackPush (StackPush),
    .StackPop  (StackPop),
    .push_data (push_data),
    .clear_err (clear_err),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .top_data  (top_data),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop_valid strobe must match the oldest expected pop word.
  always @(negedge clk) begin
    if (!reset && pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_valid", 32'd1, 32'd0);
      end else begin
        chk("pop_data", pop_data, exp_q.pop_front());
      end
    end
  end

  // One clock edge with the given request; inputs return to idle 1 time unit after the edge.
  task automatic cyc(input logic p, input logic q, input logic [31:0] d, input logic c);
    StackPush = p;
    StackPop  = q;
    push_data = d;
    clear_err = c;
    @(posedge clk);
    #1;
    StackPush = 1'b0;
    StackPop  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    cyc(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic pop_exp(input logic [31:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; StackPush = 1'b0; StackPop = 1'b0; push_data = '0; clear_err = 1'b0;
    @(posedge clk); #1;
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", pop_data, 32'd0);
    chk("rst_top", top_data, 32'd0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    reset = 1'b0;

    // Basic push/pop
    push(32'hA); push(32'hB); push(32'hC);
    chk("p3_sp", 32'(sp), 32'd3);
    chk("p3_top", top_data, 32'hC);
    pop_exp(32'hC);
    chk("pop_sp", 32'(sp), 32'd2);
    chk("pop_valid_direct", 32'(pop_valid), 32'd1);
    chk("pop_top", top_data, 32'hB);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("idle_pop_valid", 32'(pop_valid), 32'd0);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 16; i++) push(32'(i));
    chk("fill_sp", 32'(sp), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(overflow), 32'd0);
    push(32'h99);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_sp", 32'(sp), 32'd16);
    chk("ovf_top", top_data, 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
    // Swap on a full stack does not count as overflow
    exp_q.push_back(32'd16);
    cyc(1'b1, 1'b1, 32'h55, 1'b1);
    chk("swapfull_sp", 32'(sp), 32'd16);
    chk("swapfull_top", top_data, 32'h55);
    chk("swapfull_ovf_cleared", 32'(overflow), 32'd0);
    exp_q.push_back(32'h55);
    cyc(1'b1, 1'b1, 32'h66, 1'b0);
    chk("swapfull2_ovf", 32'(overflow), 32'd0);
    pop_exp(32'h66);
    for (int i = 15; i >= 1; i--) pop_exp(32'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_top", top_data, 32'd0);

    // Underflow
    cyc(1'b0, 1'b1, 32'h0, 1'b0);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_pop_valid", 32'(pop_valid), 32'd0);
    chk("unf_sp", 32'(sp), 32'd0);
    chk("unf_pop_data_held", pop_data, 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("unf_cleared", 32'(underflow), 32'd0);
    cyc(1'b0, 1'b1, 32'h0, 1'b1);
    chk("unf_set_beats_clear", 32'(underflow), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // Simultaneous push/pop on [5, 7]
    push(32'd5); push(32'd7);
    exp_q.push_back(32'd7);
    cyc(1'b1, 1'b1, 32'd9, 1'b0);
    chk("swap_sp", 32'(sp), 32'd2);
    chk("swap_top", top_data, 32'd9);
    chk("swap_pop_valid", 32'(pop_valid), 32'd1);
    pop_exp(32'd9);
    pop_exp(32'd5);

    // Simultaneous push/pop on empty stack
    cyc(1'b1, 1'b1, 32'd4, 1'b0);
    chk("epush_sp", 32'(sp), 32'd1);
    chk("epush_top", top_data, 32'd4);
    chk("epush_pop_valid", 32'(pop_valid), 32'd0);
    chk("epush_unf", 32'(underflow), 32'd1);

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) push(32'h20 + 32'(i));
    chk("pre_arst_sp", 32'(sp), 32'd5);
    StackPush = 1'b1; push_data = 32'hDEAD;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sp", 32'(sp), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_flags", {30'd0, overflow, underflow}, 32'd0);
    @(posedge clk); #1;
    chk("arst_push_ignored", 32'(sp), 32'd0);
    StackPush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    push(32'h77);
    chk("post_rst_sp", 32'(sp), 32'd1);
    chk("post_rst_top", top_data, 32'h77);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
